counter_seq_ctrl: RTL and testbench

Programmable sequencer for the team's counter datapath. It loads a count value, runs the counter up or down, and supports pause and stop. It detects terminal count and raises a one-cycle done pulse, then either halts or auto-reloads. It sits between control logic (start/stop/pause requests) and any block that needs timed or periodic events.

---
 rtl/counter_seq_ctrl.sv | 115 +++++++++++
 tb/tb_counter_seq_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: programmable up/down counter sequencer with pause,
// stop, one-cycle terminal-count done pulse and optional auto-reload.
//
// Ports:
//   clk          clock; all state changes on its rising edge
//   rst          synchronous active-high reset
//   start        begin a sequence (honoured in IDLE and DONE only)
//   stop         abort to IDLE, count cleared
//   pause        level; holds the count while high in RUN/PAUSED
//   mode_up      1 = count 0..load_val, 0 = count load_val..0
//   auto_reload  1 = restart automatically at terminal count
//   load_val     terminal/start value
//   count        current count (registered)
//   busy         high in RUN or PAUSED
//   done         one-cycle pulse at terminal count (registered)
//   state        IDLE=0, RUN=1, PAUSED=2, DONE=3
module counter_seq_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             mode_up,
   input  logic             auto_reload,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_PAUSED = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_reload;
   logic             r_dir;
   logic             r_reload_en;
   logic             r_done;

   logic [WIDTH-1:0] w_term;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_restart;
   logic             w_at_term;

   // Terminal is the latched reload when counting up, zero when down.
   assign w_term    = r_dir ? r_reload : '0;
   assign w_at_term = (r_count == w_term);
   assign w_next    = r_dir ? r_count + WIDTH'(1)
                            : r_count - WIDTH'(1);
   assign w_restart = r_dir ? '0 : r_reload;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_count     <= '0;
         r_reload    <= '0;
         r_dir       <= 1'b0;
         r_reload_en <= 1'b0;
         r_done      <= 1'b0;
      end else if (stop) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_reload    <= load_val;
                  r_dir       <= mode_up;
                  r_reload_en <= auto_reload;
                  r_count     <= mode_up ? '0 : load_val;
                  r_state     <= S_RUN;
               end
            end
            S_RUN: begin
               if (pause) begin
                  r_state <= S_PAUSED;
                  r_done  <= 1'b0;
               end else if (w_at_term) begin
                  r_done <= 1'b1;
                  // Without reload the terminal value is held in DONE.
                  if (r_reload_en) r_count <= w_restart;
                  else             r_state <= S_DONE;
               end else begin
                  r_count <= w_next;
                  r_done  <= 1'b0;
               end
            end
            S_PAUSED: begin
               r_done <= 1'b0;
               if (!pause) r_state <= S_RUN;
            end
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign count = r_count;
   assign done  = r_done;
   assign state = r_state;
   assign busy  = (r_state == S_RUN) || (r_state == S_PAUSED);

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: scoreboard bench for counter_seq_ctrl with a
// position-based reference model, directed scenarios and random traffic.
module tb_counter_seq_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic         pause = 1'b0;
   logic         mode_up = 1'b0;
   logic         auto_reload = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] count;
   logic         busy;
   logic         done;
   logic [1:0]   state;

   always #5 clk = ~clk;

   counter_seq_ctrl #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .pause       (pause),
      .mode_up     (mode_up),
      .auto_reload (auto_reload),
      .load_val    (load_val),
      .count       (count),
      .busy        (busy),
      .done        (done),
      .state       (state)
   );

   typedef struct packed {
      logic [W-1:0] count;
      logic [1:0]   state;
      logic         busy;
      logic         done;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;

   // Reference: a sequence is a walk of position k from 0 to len.
   // Visible count is k going up, len-k going down.
   int m_st   = 0;
   int m_k    = 0;
   int m_len  = 0;
   bit m_up   = 0;
   bit m_ar   = 0;
   bit m_done = 0;

   function automatic exp_t model_out();
      exp_t e;
      e.count = W'(m_up ? m_k : m_len - m_k);
      e.state = 2'(m_st);
      e.busy  = (m_st == 1) || (m_st == 2);
      e.done  = m_done;
      return e;
   endfunction

   task automatic model_step(input bit r, input bit s, input bit sp,
                             input bit pa, input bit mu, input bit ar,
                             input int lv);
      if (r) begin
         m_st = 0; m_k = 0; m_len = 0;
         m_up = 0; m_ar = 0; m_done = 0;
      end else if (sp) begin
         m_st = 0; m_k = 0; m_len = 0; m_done = 0;
      end else if ((m_st == 0 || m_st == 3) && s) begin
         m_len = lv; m_up = mu; m_ar = ar;
         m_k = 0; m_st = 1; m_done = 0;
      end else if (m_st == 1) begin
         if (pa) begin
            m_st = 2; m_done = 0;
         end else if (m_k == m_len) begin
            m_done = 1;
            if (m_ar) m_k = 0;
            else      m_st = 3;
         end else begin
            m_k++; m_done = 0;
         end
      end else if (m_st == 2) begin
         m_done = 0;
         if (!pa) m_st = 1;
      end else begin
         m_done = 0;
      end
   endtask

   task automatic drive(input bit r, input bit s, input bit sp,
                        input bit pa, input bit mu, input bit ar,
                        input int lv);
      @(negedge clk);
      rst = r; start = s; stop = sp; pause = pa;
      mode_up = mu; auto_reload = ar; load_val = W'(lv);
      model_step(r, s, sp, pa, mu, ar, lv);
      sb.push_back(model_out());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: the DUT presents a fresh output every edge.
   initial begin
      exp_t e;
      exp_t a;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            a = {count, state, busy, done};
            n_vec++;
            if (a !== e) begin
               n_err++;
               $display("FAIL cyc%0d out: got cnt=%0d st=%0d busy=%0b done=%0b want cnt=%0d st=%0d busy=%0b done=%0b",
                        cyc, a.count, a.state, a.busy, a.done,
                        e.count, e.state, e.busy, e.done);
            end
         end
      end
   end

   initial begin
      int lv;
      int r;
      // Reset and idle
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      idle(3);
      // Down one-shot, load 3
      drive(0, 1, 0, 0, 0, 0, 3);
      idle(6);
      // Up auto-reload, load 2; start mid-run must be ignored
      drive(0, 1, 0, 0, 1, 1, 2);
      idle(4);
      drive(0, 1, 0, 0, 0, 0, 7);
      idle(5);
      drive(0, 0, 1, 0, 0, 0, 0);
      // Pause at count 2, resume, stop
      drive(0, 1, 0, 0, 1, 0, 5);
      idle(2);
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0, 0, 0);
      idle(3);
      drive(0, 0, 1, 0, 0, 0, 0);
      // load_val 0 with auto-reload: done every cycle
      drive(0, 1, 0, 0, 1, 1, 0);
      idle(4);
      drive(0, 1, 0, 0, 0, 1, 0);
      idle(3);
      // start and stop together
      drive(0, 1, 1, 0, 1, 0, 4);
      idle(2);
      // Reset mid-run at count 4
      drive(0, 1, 0, 0, 1, 0, 9);
      idle(4);
      drive(1, 1, 1, 1, 1, 1, 9);
      idle(2);
      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         r  = int'($urandom_range(0, 99));
         lv = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255))
                                          : int'($urandom_range(0, 7));
         drive(r < 1,
               $urandom_range(0, 9) < 2,
               (r >= 1) && (r < 3),
               $urandom_range(0, 9) < 2,
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)),
               lv);
      end
      idle(2);
      repeat (3) @(negedge clk);
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
